score_keeper: RTL

Parametrised score unit for the duck-shooting game; it replaces the fixed 8-bit hit counter. It edge-detects hit, miss and game-over strobes from the game logic, so multi-cycle level inputs count once. It awards weighted points with a streak multiplier, saturates the score, and tracks a session high score. Outputs feed the on-screen score text renderer.

---
 rtl/score_keeper.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Score unit for the duck-shooting game: edge-detected events, streak multiplier,
// saturating score and session high score. Define BCD_OUT_EN to build the decimal converter.
module score_keeper #(
   parameter int unsigned SCORE_W    = 16,
   parameter int unsigned PTS_W      = 4,
   parameter int unsigned MULT_MAX   = 4,
   parameter int unsigned BCD_DIGITS = 5
) (
   input  logic                    pclk,
   input  logic                    rst_n,
   input  logic                    new_game,
   input  logic                    hit,
   input  logic [PTS_W-1:0]        hit_pts,
   input  logic                    miss,
   input  logic                    game_over,
   output logic [SCORE_W-1:0]      score,
   output logic [SCORE_W-1:0]      high_score,
   output logic [2:0]              multiplier,
   output logic                    playing,
   output logic                    new_record,
   output logic [4*BCD_DIGITS-1:0] bcd_score,
   output logic                    bcd_valid
);

   localparam int unsigned PROD_W = PTS_W + 3;
   localparam int unsigned SUM_W  = SCORE_W + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [2:0]         MULT_TOP  = 3'(MULT_MAX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_OVER
   } state_t;

   state_t state_q, state_d;

   logic new_game_q, hit_q, miss_q, game_over_q;
   logic ng_rise, hit_rise, miss_rise, go_rise;

   logic [PROD_W-1:0]  prod;
   logic [SUM_W-1:0]   sum;
   logic [SCORE_W-1:0] hit_score;
   logic [2:0]         mult_inc;

   logic [SCORE_W-1:0] score_d, high_d;
   logic [2:0]         mult_d;
   logic               rec_d, playing_d;

   // One-flop history per strobe so a held level counts once
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         new_game_q  <= 1'b0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         new_game_q  <= new_game;
         hit_q       <= hit;
         miss_q      <= miss;
         game_over_q <= game_over;
      end
   end

   assign ng_rise   = new_game & ~new_game_q;
   assign hit_rise  = hit & ~hit_q;
   assign miss_rise = miss & ~miss_q;
   assign go_rise   = game_over & ~game_over_q;

   // Weighted points with one spare sum bit to detect overflow
   assign prod      = PROD_W'(hit_pts) * PROD_W'(multiplier);
   assign sum       = SUM_W'(score) + SUM_W'(prod);
   assign hit_score = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
   assign mult_inc  = (multiplier >= MULT_TOP) ? MULT_TOP : multiplier + 3'd1;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         score      <= '0;
         high_score <= '0;
         multiplier <= 3'd1;
         playing    <= 1'b0;
         new_record <= 1'b0;
      end else begin
         state_q    <= state_d;
         score      <= score_d;
         high_score <= high_d;
         multiplier <= mult_d;
         playing    <= playing_d;
         new_record <= rec_d;
      end
   end

   // Next state and score bookkeeping; new_game overrides every other event
   always_comb begin
      state_d = state_q;
      score_d = score;
      high_d  = high_score;
      mult_d  = multiplier;
      rec_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (ng_rise) begin
               state_d = ST_PLAY;
               score_d = '0;
               mult_d  = 3'd1;
            end
         end
         ST_PLAY: begin
            if (ng_rise) begin
               score_d = '0;
               mult_d  = 3'd1;
            end else begin
               if (hit_rise) begin
                  score_d = hit_score;
                  mult_d  = mult_inc;
               end
               if (miss_rise) begin
                  mult_d = 3'd1;
               end
               if (go_rise) begin
                  state_d = ST_OVER;
                  if (score_d > high_score) begin
                     high_d = score_d;
                     rec_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      playing_d = (state_d == ST_PLAY);
   end

`ifdef BCD_OUT_EN
   localparam int unsigned BCD_W = 4 * BCD_DIGITS;
   localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] bin_q;
   logic [BCD_W-1:0]   work_q, work_adj, work_shift;
   logic [CNT_W-1:0]   cnt_q;

   // One double-dabble step: add 3 to digits >= 5, then shift in the next binary bit
   always_comb begin
      work_adj = work_q;
      for (int d = 0; d < int'(BCD_DIGITS); d++) begin
         if (work_q[4*d +: 4] >= 4'd5) begin
            work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
         end
      end
      work_shift = {work_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
   end

   // A score change always restarts, aborting any conversion in flight
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q     <= '0;
         work_q    <= '0;
         cnt_q     <= '0;
         bcd_score <= '0;
         bcd_valid <= 1'b1;
      end else if (score_d != score) begin
         bin_q     <= score_d;
         work_q    <= '0;
         cnt_q     <= CNT_W'(SCORE_W);
         bcd_valid <= 1'b0;
      end else if (!bcd_valid) begin
         bin_q  <= {bin_q[SCORE_W-2:0], 1'b0};
         work_q <= work_shift;
         cnt_q  <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            bcd_score <= work_shift;
            bcd_valid <= 1'b1;
         end
      end
   end
`else
   assign bcd_score = '0;
   assign bcd_valid = 1'b1;
`endif

endmodule
